fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, output register plus 1-entry skid.
// Optional perf counters o_fetch_cnt/o_stall_cnt are built when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer #(
  parameter int unsigned         XLEN         = 32,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instruction
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     o_fetch_cnt,
  output logic [31:0]     o_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_t;

  state_t          r_state;
  logic            r_imem_req;
  logic [XLEN-1:0] r_imem_addr;
  logic [XLEN-1:0] r_next;
  logic            r_drop;
  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_pc;
  logic [XLEN-1:0] r_skid_instr;

  logic            w_consume;
  logic            w_resp_take;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_seq_addr;

  assign w_consume   = r_valid & ~i_stall;
  assign w_resp_take = (r_state == S_WAIT) & i_imem_rvalid & ~i_redirect;
  assign w_target    = i_redirect_pc & ~(XLEN'(3));
  assign w_seq_addr  = r_imem_addr + XLEN'(4);

  // r_imem_addr still holds the granted address while in WAIT, so it tags the response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid      <= 1'b0;
      r_pc         <= RESET_VECTOR;
      r_instr      <= '0;
      r_skid_valid <= 1'b0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else if (i_redirect) begin
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_resp_take) begin
      if (!r_valid || w_consume) begin
        r_valid <= 1'b1;
        r_pc    <= r_imem_addr;
        r_instr <= i_imem_rdata;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_pc    <= r_imem_addr;
        r_skid_instr <= i_imem_rdata;
      end
    end else if (w_consume) begin
      if (r_skid_valid) begin
        r_pc         <= r_skid_pc;
        r_instr      <= r_skid_instr;
        r_skid_valid <= 1'b0;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_REQ;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_VECTOR;
      r_next      <= RESET_VECTOR;
      r_drop      <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (!r_imem_req) begin
            r_imem_req <= 1'b1;
            if (i_redirect) r_imem_addr <= w_target;
          end else if (i_imem_gnt) begin
            r_imem_req <= 1'b0;
            r_drop     <= 1'b0;
            if (i_redirect || r_drop) begin
              r_state <= S_DRAIN;
              if (i_redirect) r_next <= w_target;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (i_redirect) begin
            // Request must stay stable until granted; remember to discard its response.
            r_drop <= 1'b1;
            r_next <= w_target;
          end
        end
        S_WAIT: begin
          if (i_redirect) begin
            if (i_imem_rvalid) begin
              r_state     <= S_REQ;
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_target;
            end else begin
              r_state <= S_DRAIN;
              r_next  <= w_target;
            end
          end else if (i_imem_rvalid) begin
            if (!r_valid || w_consume) begin
              r_state     <= S_REQ;
              r_imem_req  <= 1'b1;
              r_imem_addr <= w_seq_addr;
            end else begin
              r_state <= S_HOLD;
              r_next  <= w_seq_addr;
            end
          end
        end
        S_DRAIN: begin
          if (i_imem_rvalid) begin
            r_state     <= S_REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= i_redirect ? w_target : r_next;
          end else if (i_redirect) begin
            r_next <= w_target;
          end
        end
        default: begin
          if (i_redirect || w_consume) begin
            r_state     <= S_REQ;
            r_imem_req  <= 1'b1;
            r_imem_addr <= i_redirect ? w_target : r_next;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_consume)         r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_valid && i_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_fetch_cnt = r_fetch_cnt;
  assign o_stall_cnt = r_stall_cnt;
`endif

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_imem_addr;
  assign o_valid       = r_valid;
  assign o_pc          = r_pc;
  assign o_instruction = r_instr;

endmodule
